// File: rtl/qs_stream_sorter_pkg.sv
// Shared types and the ordering predicate for the streaming insertion sorter.
package qs_stream_sorter_pkg;

    // Widest data word any instance may use; narrower instances zero the upper bits.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    typedef struct packed {
        logic             vld;
        logic [MAX_W-1:0] dat;
    } cell_t;

    // True when a sorts strictly before b; an empty cell sorts after everything.
    function automatic logic is_before(input cell_t a, input cell_t b, input logic desc);
        logic res;
        if (!a.vld) begin
            res = 1'b0;
        end else if (!b.vld) begin
            res = 1'b1;
        end else begin
            res = desc ? (a.dat > b.dat) : (a.dat < b.dat);
        end
        return res;
    endfunction

endpackage

// File: rtl/qs_stream_sorter_cell.sv
// One systolic insertion cell: keep, take the new word, take the left neighbour,
// or shift in the right neighbour while draining.
module qs_stream_sorter_cell
    import qs_stream_sorter_pkg::*;
#(
    parameter bit IS_FIRST = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  ins,
    input  logic  pop,
    input  logic  desc,
    input  cell_t x,
    input  cell_t prev,
    input  cell_t nxt,
    output cell_t cell_r
);

    cell_t cell_q, cell_d;
    logic  self_after;
    logic  prev_after;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cell_d     = cell_q;
        self_after = is_before(x, cell_q, desc);
        prev_after = is_before(x, prev, desc);
        if (clr) begin
            cell_d = (IS_FIRST && ins) ? x : '0;
        end else if (pop) begin
            cell_d = nxt;
        end else if (ins && self_after) begin
            // Equal keys are never "after", so a repeated key lands behind its twin.
            cell_d = (IS_FIRST || !prev_after) ? x : prev;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: only the valid bit needs reset; stale data in an empty cell is never observed.
        if (!rst) begin
            cell_q.vld <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all cells update together.
            cell_q <= cell_d;
        end
    end

    assign cell_r = cell_q;

endmodule

// File: rtl/qs_stream_sorter.sv
// Streaming packet sorter: packet FSM, length/drain counters, output register
// and an N-deep array of insertion cells.
module qs_stream_sorter
    import qs_stream_sorter_pkg::*;
#(
    parameter int W     = 32,
    parameter int N     = 16,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_desc,
    input  logic         in_vld,
    input  logic         in_sop,
    input  logic         in_eop,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy_r,
    input  logic         out_rdy,
    output logic         out_vld_r,
    output logic         out_sop_r,
    output logic         out_eop_r,
    output logic         out_err_r,
    output logic [W-1:0] out_dat_r,
    output logic [15:0]  stat_drop_r
);

    state_t             state_q, state_d;
    logic               in_rdy_q, in_rdy_d;
    logic               desc_q, desc_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic               out_vld_q, out_vld_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic               out_err_q, out_err_d;
    logic [W-1:0]       out_dat_q, out_dat_d;
    logic [15:0]        drop_q, drop_d;

    logic               acc;
    logic               ins;
    logic               clr;
    logic               pop;
    logic               load_ok;
    logic               cur_desc;
    cell_t              x;
    cell_t              cells_q [N];

    always_comb begin
        state_d   = state_q;
        in_rdy_d  = in_rdy_q;
        desc_d    = desc_q;
        err_d     = err_q;
        len_d     = len_q;
        pop_cnt_d = pop_cnt_q;
        out_vld_d = out_vld_q;
        out_sop_d = out_sop_q;
        out_eop_d = out_eop_q;
        out_err_d = out_err_q;
        out_dat_d = out_dat_q;
        drop_d    = drop_q;
        ins       = 1'b0;
        clr       = 1'b0;
        pop       = 1'b0;
        load_ok   = 1'b0;
        acc       = in_vld && in_rdy_q;
        cur_desc  = (acc && in_sop) ? cfg_desc : desc_q;
        x         = '0;
        x.vld     = 1'b1;
        x.dat[W-1:0] = in_dat;

        case (state_q)
            IDLE: begin
                if (acc && in_sop) begin
                    desc_d    = cfg_desc;
                    ins       = 1'b1;
                    len_d     = CNT_W'(1);
                    err_d     = 1'b0;
                    pop_cnt_d = '0;
                    if (in_eop) begin
                        state_d  = DRAIN;
                        in_rdy_d = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (acc) begin
                    if (in_sop) begin
                        // Abort: the new sop word restarts the array in the same cycle.
                        clr    = 1'b1;
                        ins    = 1'b1;
                        desc_d = cfg_desc;
                        len_d  = CNT_W'(1);
                        err_d  = 1'b0;
                        drop_d = (drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
                    end else if (len_q == CNT_W'(N)) begin
                        err_d = 1'b1;
                    end else begin
                        ins   = 1'b1;
                        len_d = len_q + CNT_W'(1);
                    end
                    if (in_eop) begin
                        state_d  = DRAIN;
                        in_rdy_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                load_ok = !out_vld_q || out_rdy;
                if (load_ok && (pop_cnt_q < len_q)) begin
                    pop       = 1'b1;
                    out_vld_d = 1'b1;
                    out_dat_d = cells_q[0].dat[W-1:0];
                    out_sop_d = (pop_cnt_q == '0);
                    out_eop_d = (pop_cnt_q == len_q - CNT_W'(1));
                    out_err_d = (pop_cnt_q == len_q - CNT_W'(1)) && err_q;
                    pop_cnt_d = pop_cnt_q + CNT_W'(1);
                end else if (out_vld_q && out_rdy) begin
                    out_vld_d = 1'b0;
                    out_sop_d = 1'b0;
                    out_eop_d = 1'b0;
                    out_err_d = 1'b0;
                end
                if (out_vld_q && out_rdy && out_eop_q) begin
                    state_d  = IDLE;
                    in_rdy_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                in_rdy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            in_rdy_q  <= 1'b1;
            desc_q    <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= '0;
            pop_cnt_q <= '0;
            out_vld_q <= 1'b0;
            out_sop_q <= 1'b0;
            out_eop_q <= 1'b0;
            out_err_q <= 1'b0;
            out_dat_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            in_rdy_q  <= in_rdy_d;
            desc_q    <= desc_d;
            err_q     <= err_d;
            len_q     <= len_d;
            pop_cnt_q <= pop_cnt_d;
            out_vld_q <= out_vld_d;
            out_sop_q <= out_sop_d;
            out_eop_q <= out_eop_d;
            out_err_q <= out_err_d;
            out_dat_q <= out_dat_d;
            drop_q    <= drop_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cell
        cell_t prev;
        cell_t nxt;
        if (i == 0) begin : g_head
            assign prev = '0;
        end else begin : g_body
            assign prev = cells_q[i-1];
        end
        if (i == N - 1) begin : g_tail
            assign nxt = '0;
        end else begin : g_link
            assign nxt = cells_q[i+1];
        end
        qs_stream_sorter_cell #(
            .IS_FIRST (i == 0)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .ins    (ins),
            .pop    (pop),
            .desc   (cur_desc),
            .x      (x),
            .prev   (prev),
            .nxt    (nxt),
            .cell_r (cells_q[i])
        );
    end

    assign in_rdy_r    = in_rdy_q;
    assign out_vld_r   = out_vld_q;
    assign out_sop_r   = out_sop_q;
    assign out_eop_r   = out_eop_q;
    assign out_err_r   = out_err_q;
    assign out_dat_r   = out_dat_q;
    assign stat_drop_r = drop_q;

endmodule

// File: tb/tb_qs_stream_sorter.sv
// Directed bench for qs_stream_sorter: scoreboard of expected sorted words,
// compared by a monitor on every output handshake.
module tb_qs_stream_sorter;

    localparam int W = 32;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_desc = 1'b0;
    logic         in_vld = 1'b0;
    logic         in_sop = 1'b0;
    logic         in_eop = 1'b0;
    logic [W-1:0] in_dat = '0;
    logic         in_rdy_r;
    logic         out_rdy = 1'b1;
    logic         out_vld_r;
    logic         out_sop_r;
    logic         out_eop_r;
    logic         out_err_r;
    logic [W-1:0] out_dat_r;
    logic [15:0]  stat_drop_r;

    int vectors = 0;
    int miscompares = 0;
    logic [W+2:0] sb [$];

    always #5 clk = ~clk;

    qs_stream_sorter #(.W(W), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_desc    (cfg_desc),
        .in_vld      (in_vld),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_dat      (in_dat),
        .in_rdy_r    (in_rdy_r),
        .out_rdy     (out_rdy),
        .out_vld_r   (out_vld_r),
        .out_sop_r   (out_sop_r),
        .out_eop_r   (out_eop_r),
        .out_err_r   (out_err_r),
        .out_dat_r   (out_dat_r),
        .stat_drop_r (stat_drop_r)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] dat, input logic sop, input logic eop, input logic err);
        sb.push_back({err, eop, sop, dat});
    endtask

    // Drive one beat from just after a rising edge; returns just after its handshake edge.
    task automatic send(input logic sop, input logic eop, input logic [W-1:0] dat);
        int n;
        in_vld = 1'b1;
        in_sop = sop;
        in_eop = eop;
        in_dat = dat;
        n = 0;
        @(negedge clk);
        while (!in_rdy_r && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_rdy_r || out_vld_r) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(n < 300), 64'(1));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && out_vld_r && out_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(out_dat_r), 64'hDEAD_0000_0000_0000);
            end else begin
                check("out_word", 64'({out_err_r, out_eop_r, out_sop_r, out_dat_r}), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", 64'(in_rdy_r), 64'(1));
        check("rst_out", 64'({out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r}), 64'(0));
        check("rst_drop", 64'(stat_drop_r), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Word without sop in IDLE is dropped silently
        send(1'b0, 1'b1, 32'd77);
        repeat (3) @(posedge clk);
        #1;
        check("idle_nosop_drop", 64'(stat_drop_r), 64'(0));

        // Ascending 5,3,9,1 with latency check
        cfg_desc = 1'b0;
        push_exp(32'd1, 1'b1, 1'b0, 1'b0);
        push_exp(32'd3, 1'b0, 1'b0, 1'b0);
        push_exp(32'd5, 1'b0, 1'b0, 1'b0);
        push_exp(32'd9, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 32'd5);
        send(1'b0, 1'b0, 32'd3);
        send(1'b0, 1'b0, 32'd9);
        send(1'b0, 1'b1, 32'd1);
        @(negedge clk);
        check("lat_cycle1_idle", 64'(out_vld_r), 64'(0));
        check("drain_in_rdy", 64'(in_rdy_r), 64'(0));
        @(negedge clk);
        check("lat_cycle2_first", 64'({out_vld_r, out_sop_r}), 64'(2'b11));
        wait_drain();

        // Descending 7,7,2,8
        cfg_desc = 1'b1;
        push_exp(32'd8, 1'b1, 1'b0, 1'b0);
        push_exp(32'd7, 1'b0, 1'b0, 1'b0);
        push_exp(32'd7, 1'b0, 1'b0, 1'b0);
        push_exp(32'd2, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 32'd7);
        cfg_desc = 1'b0;
        send(1'b0, 1'b0, 32'd7);
        send(1'b0, 1'b0, 32'd2);
        send(1'b0, 1'b1, 32'd8);
        wait_drain();

        // Overflow: 18 words 17..0, only 17..2 kept
        cfg_desc = 1'b0;
        for (int v = 2; v <= 17; v++) begin
            push_exp(W'(v), v == 2, v == 17, v == 17);
        end
        for (int i = 0; i < 18; i++) begin
            send(i == 0, i == 17, W'(17 - i));
        end
        wait_drain();

        // Backpressure during drain of 4,2
        out_rdy = 1'b0;
        push_exp(32'd2, 1'b1, 1'b0, 1'b0);
        push_exp(32'd4, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 32'd4);
        send(1'b0, 1'b1, 32'd2);
        @(negedge clk);
        @(negedge clk);
        check("bp_hold_a", 64'({out_vld_r, out_sop_r, out_dat_r}), 64'({2'b11, 32'd2}));
        @(negedge clk);
        check("bp_hold_b", 64'({out_vld_r, out_sop_r, out_dat_r}), 64'({2'b11, 32'd2}));
        check("bp_in_rdy", 64'(in_rdy_r), 64'(0));
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        @(negedge clk);
        check("bp_second", 64'({out_vld_r, out_eop_r, out_dat_r}), 64'({2'b11, 32'd4}));
        check("bp_in_rdy2", 64'(in_rdy_r), 64'(0));
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        wait_drain();

        // Abort: sop 10, 20 then sop+eop 6
        push_exp(32'd6, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 32'd10);
        send(1'b0, 1'b0, 32'd20);
        send(1'b1, 1'b1, 32'd6);
        wait_drain();
        check("abort_drop_cnt", 64'(stat_drop_r), 64'(1));

        // Reset mid-DRAIN after one of three words consumed
        out_rdy = 1'b0;
        push_exp(32'd10, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 32'd30);
        send(1'b0, 1'b0, 32'd10);
        send(1'b0, 1'b1, 32'd20);
        repeat (3) @(posedge clk);
        #1;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_out", 64'({out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r}), 64'(0));
        check("midrst_in_rdy", 64'(in_rdy_r), 64'(1));
        check("midrst_drop", 64'(stat_drop_r), 64'(0));
        check("midrst_sb_empty", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_rdy = 1'b1;
        push_exp(32'd0, 1'b1, 1'b0, 1'b0);
        push_exp(32'd1, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 32'd1);
        send(1'b0, 1'b1, 32'd0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qs_stream_sorter.md
Name: qs_stream_sorter

Overview:
- Parametrised streaming sorter: next generation of the `qs` packet sorter, without the micro-coded core.
- Accepts packets of up to N unsigned W-bit words on a vld/sop/eop/rdy interface and sorts them on arrival with a systolic insertion array (one word per cycle).
- Drains the sorted packet with output backpressure; ascending/descending order is selected per packet.
- Sits in place of `qs` behind the same command interface. It is the building block for multi-channel sort farms.

Parameters:
- W, 32, data word width in bits.
- N, 16, maximum words per packet (array depth); N >= 2.
- CNT_W, $clog2(N+1), width of occupancy/length counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- cfg_desc  input  1  sort order; sampled on sop handshake: 0 ascending, 1 descending.
- in_vld  input  1  input word valid.
- in_sop  input  1  first word of packet.
- in_eop  input  1  last word of packet.
- in_dat  input  W  input word (unsigned).
- in_rdy_r  output  1  input ready, registered.
- out_rdy  input  1  downstream ready.
- out_vld_r  output  1  output word valid, registered.
- out_sop_r  output  1  first sorted word.
- out_eop_r  output  1  last sorted word.
- out_err_r  output  1  packet overflowed; valid only with out_eop_r.
- out_dat_r  output  W  sorted word.
- stat_drop_r  output  16  count of aborted packets; saturating.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; in_rdy_r=1; all out_*_r=0; stat_drop_r=0.
  - All array cells invalid; counters=0.
  - Reset asserted mid-LOAD or mid-DRAIN discards the packet with no output.
- Handshakes: input accepted when in_vld & in_rdy_r; output word consumed when out_vld_r & out_rdy.
- out_* are held stable while out_vld_r & !out_rdy.
- FSM IDLE -> LOAD -> DRAIN -> IDLE:
  - IDLE: accepted word without sop is dropped silently. Accepted sop latches cfg_desc, inserts the word, len=1, err=0. With eop also set, go to DRAIN; otherwise go to LOAD.
  - LOAD: each accepted word is inserted, len+1.
    - If len==N, the word is discarded and err=1 (len not incremented).
    - Accepted eop -> DRAIN; in_rdy_r=0 from the next cycle.
    - Accepted sop in LOAD aborts the current packet: array cleared, stat_drop_r+1, the new word becomes word 0 of a fresh packet (same cycle).
  - DRAIN: in_rdy_r=0.
    - Cell 0 loads the output register whenever the register is empty or being consumed; the array shifts toward cell 0 each such pop.
    - out_sop_r on the first word; out_eop_r and out_err_r on word len.
    - Consumption of the eop word -> IDLE; in_rdy_r=1 the following cycle.
- Insertion cell i (key "before" = `<` ascending, `>` descending; invalid cells compare as after everything):
  - keeps its value if its own value is not after x;
  - otherwise takes x if i==0 or cell i-1 is not after x;
  - otherwise takes cell i-1.
  - Equal keys keep arrival order (stable).
- Latency: first output word (out_vld_r & out_sop_r) appears 2 cycles after the eop handshake cycle. With out_rdy held high there is one word per cycle; N-word packet turnaround is N+3 cycles.
- Simultaneous events: sop & eop on the same beat is a 1-word packet. A dropped overflow word that carries eop still ends the packet.

Decomposition:
- Package qs_stream_sorter_pkg:
  - state_t enum {IDLE, LOAD, DRAIN};
  - cell_t struct {vld, dat[W]};
  - function is_before(a, b, desc).
- Sub-module qs_stream_sorter_cell: one insertion/shift cell, instantiated N times via generate. The top holds the FSM, counters and output register.

Test Plan:
- Ascending, N=16: input 5,3,9,1 (sop on 5, eop on 1), out_rdy=1 -> 1,3,5,9 with sop on 1, eop on 9, err=0; first out_vld_r 2 cycles after the eop beat.
- cfg_desc=1, input 7,7,2,8 -> 8,7,7,2; the equal 7s leave in arrival order.
- Overflow: 18 words 17..0 with N=16 -> 16 words 2..17 ascending; out_err_r=1 on the eop beat; words 1 and 0 dropped.
- Backpressure: toggle out_rdy 1,0,0,1… during drain of 4,2 -> out_dat_r holds 2 while stalled, then 4 with eop; in_rdy_r=0 throughout the drain.
- Abort: sop,10,20 then sop,6 & eop -> single output word 6 with sop & eop; stat_drop_r=1.
- Reset mid-DRAIN after 1 of 3 words consumed -> all outputs 0 next cycle, in_rdy_r=1; a new packet 1 then 0 outputs 0,1.
